// File: rtl/instr_encoder.sv
// instr_encoder: turns decoded RV32I instruction requests into 32-bit words
// and streams them, with sequential byte addresses, into instruction memory.
// One registered output stage (valid/ready both sides) and a fill FSM that
// stops after DEPTH words until the next start pulse.
// Optional immediate range checking: define INSTR_ENCODER_IMM_CHECK_EN.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, holds with its payload stable until the
// transfer. in_ready never depends on in_valid.
module instr_encoder #(
    parameter int ADDR_W    = 32,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 256
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 op_class,
    input  logic                       alt,
    input  logic [2:0]                 funct3,
    input  logic [4:0]                 rd,
    input  logic [4:0]                 rs1,
    input  logic [4:0]                 rs2,
    input  logic [31:0]                imm,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [ADDR_W-1:0]          out_addr,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] word_count,
`ifdef INSTR_ENCODER_IMM_CHECK_EN
    output logic                       imm_err,
    output logic                       imm_err_sticky,
`endif
    output logic [1:0]                 state_dbg
);

    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW:0]       DEPTH_X  = (CW+1)'(DEPTH);
    localparam logic [CW-1:0]     LAST_CNT = CW'(DEPTH-1);
    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic        accept;
    logic        out_hs;
    logic        last_hs;
    logic [CW:0] pending;
    logic [31:0] enc;
    logic        is_shift;
    logic        r_alt;

    assign state_dbg = state_q;
    assign full      = (state_q == ST_FULL);

    // Words already written plus the one waiting in the output register
    // must stay below DEPTH for a new request to be taken.
    assign pending  = {1'b0, word_count} + {{CW{1'b0}}, out_valid};
    assign in_ready = (state_q == ST_RUN) && !start && (!out_valid || out_ready)
                      && (pending < DEPTH_X);
    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;
    assign last_hs  = out_hs && (word_count == LAST_CNT);

    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign r_alt    = alt && ((funct3 == 3'b000) || (funct3 == 3'b101));

    // Field packing for each instruction class.
    always_comb begin
        enc = 32'd0;
        case (op_class)
            3'd0: enc = {imm[11:0], rs1, funct3, rd, OP_LOAD};
            3'd1: enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
            3'd2: enc = {1'b0, r_alt, 5'b00000, rs2, rs1, funct3, rd, OP_RTYPE};
            3'd3: begin
                if (is_shift)
                    enc = {1'b0, alt, 5'b00000, imm[4:0], rs1, funct3, rd, OP_ITYPE};
                else
                    enc = {imm[11:0], rs1, funct3, rd, OP_ITYPE};
            end
            3'd4: enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
            3'd5: enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            3'd6: enc = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
            3'd7: enc = {imm[31:12], rd, (alt ? OP_AUIPC : OP_LUI)};
            default: enc = 32'd0;
        endcase
    end

`ifdef INSTR_ENCODER_IMM_CHECK_EN
    logic imm_bad;

    // Flags immediates that do not fit the field they are packed into.
    always_comb begin
        imm_bad = 1'b0;
        case (op_class)
            3'd0, 3'd1, 3'd6: imm_bad = (imm[31:11] != {21{imm[11]}});
            3'd3: begin
                if (is_shift)
                    imm_bad = (imm[31:5] != 27'd0);
                else
                    imm_bad = (imm[31:11] != {21{imm[11]}});
            end
            3'd4:    imm_bad = (imm[31:12] != {20{imm[12]}}) || imm[0];
            3'd5:    imm_bad = (imm[31:20] != {12{imm[20]}}) || imm[0];
            3'd7:    imm_bad = (imm[11:0] != 12'd0);
            default: imm_bad = 1'b0;
        endcase
    end

    // Error flag travels with its word; sticky flag spans the whole fill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imm_err        <= 1'b0;
            imm_err_sticky <= 1'b0;
        end else if (start) begin
            imm_err        <= 1'b0;
            imm_err_sticky <= 1'b0;
        end else if (accept) begin
            imm_err        <= imm_bad;
            imm_err_sticky <= imm_err_sticky | imm_bad;
        end
    end
`endif

    // Fill FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Fill FSM next state: start always (re)enters RUN; the DEPTH-th
    // write completes the fill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (start)        state_d = ST_RUN;
                else if (last_hs) state_d = ST_FULL;
            end
            ST_FULL: if (start) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output register, address and word counter. out_addr always names the
    // word currently presented (or the next one when nothing is pending).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_instr  <= 32'd0;
            out_addr   <= BASE_A;
            word_count <= '0;
        end else if (start) begin
            out_valid  <= 1'b0;
            out_addr   <= BASE_A;
            word_count <= '0;
        end else begin
            if (out_hs) begin
                out_addr   <= out_addr + ADDR_W'(4);
                word_count <= word_count + CW'(1);
            end
            if (accept) begin
                out_valid <= 1'b1;
                out_instr <= enc;
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Converts decoded instruction requests into 32-bit RV32I instruction words.
- Covers every class the core's control decoder recognises: load, store, R-type, I-type ALU, branch, JAL, JALR, LUI/AUIPC.
- Streams the words with sequential write addresses into instruction memory; used by the boot/self-test loader to build programs in hardware.
- One-deep registered pipeline with valid/ready on both sides, plus a fill-state FSM bounded by DEPTH.

Parameters:
- ADDR_W, 32, width of out_addr.
- BASE_ADDR, 0, byte address of first word written after start.
- DEPTH, 256, maximum words per program fill (>=1).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; begins/restarts a program fill.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- op_class  input  3  0 LOAD, 1 STORE, 2 RTYPE, 3 ITYPE, 4 BRANCH, 5 JAL, 6 JALR, 7 UPPER.
- alt  input  1  RTYPE/ITYPE: funct7[5] (SUB/SRA/SRAI); UPPER: 1=AUIPC, 0=LUI; ignored otherwise.
- funct3  input  3  funct3 field; forced 000 for JALR, ignored for JAL/UPPER.
- rd, rs1, rs2  input  5 each  register fields; unused fields are ignored and encode as imm/zero bits.
- imm  input  32  full immediate value (byte offset for B/J, full upper value for U).
- out_valid  output  1  encoded word valid; acts as memory write enable.
- out_ready  input  1  memory accepts word.
- out_instr  output  32  encoded instruction.
- out_addr  output  ADDR_W  byte address for out_instr.
- full  output  1  DEPTH words written; fill complete.
- word_count  output  $clog2(DEPTH+1)  words written since start.

Behaviour:
- Reset, asynchronous: state=IDLE; out_valid=0, out_instr=0, out_addr=BASE_ADDR, full=0, word_count=0.
- FSM states and transitions:
  - IDLE → RUN on start.
  - RUN → FULL when the DEPTH-th output handshake completes.
  - FULL → RUN on start.
  - start in RUN: restarts the fill. Address=BASE_ADDR, word_count=0, full=0, and any pending out_valid word is discarded.
- in_ready = (state==RUN) && !start && (!out_valid || out_ready) && (word_count + out_valid < DEPTH).
- Latency: accepted request appears on out_instr/out_valid the next cycle. Full throughput, 1 word/cycle, when out_ready stays high.
- out_instr/out_addr hold stable while out_valid && !out_ready.
- On output handshake: out_addr += 4 and word_count += 1. out_addr of each word equals BASE_ADDR + 4*index; no wrap within a fill.
- Opcodes: LOAD 0000011, STORE 0100011, RTYPE 0110011, ITYPE 0010011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
- Field formats:
  - I (LOAD, ITYPE, JALR): imm[11:0], rs1, funct3, rd.
  - ITYPE with funct3 001/101: bits[31:25] = {0, alt, 00000}, bits[24:20] = imm[4:0].
  - R: funct7 = {0, alt, 00000}; alt honoured only for funct3 000/101, forced 0 otherwise.
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0].
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11].
  - U: imm[31:12], rd.
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd.
- Out-of-range immediate bits are truncated silently; see the optional feature for checking.

Optional Feature:
- Macro: INSTR_ENCODER_IMM_CHECK_EN.
- When defined, extra outputs:
  - imm_err (1): registered with the word.
  - imm_err_sticky (1): cleared by reset/start.
- imm_err is set when:
  - I/S: imm is not the sign-extension of imm[11:0].
  - B: imm is not the sign-extension of imm[12:0], or imm[0]=1.
  - J: imm is not the sign-extension of imm[20:0], or imm[0]=1.
  - U: imm[11:0] != 0.
  - ITYPE shift: imm[31:5] != 0.
- The word is still emitted.
- When undefined: ports absent, no check logic.

Test Plan:
- start; ITYPE f3=000 rd=1 rs1=0 imm=5 → out_instr=0x00500093, out_addr=0x0 one cycle after accept.
- RTYPE f3=000 rd=3 rs1=1 rs2=2, alt=0 then alt=1 back-to-back, out_ready=1 → 0x002081B3 @0x0, then 0x402081B3 @0x4 on consecutive cycles.
- STORE f3=010 rs1=1 rs2=2 imm=8 → 0x0020A423; BRANCH f3=000 rs1=1 rs2=2 imm=8 → 0x00208463; JAL rd=1 imm=16 → 0x010000EF; UPPER alt=0 rd=5 imm=0x12345000 → 0x123452B7.
- out_ready=0 for 3 cycles with 2 requests queued → out_instr/out_addr stable, in_ready=0, no word lost or duplicated; both appear in order after release.
- DEPTH=4: 5 requests → 4 handshakes at 0x0–0xC, full=1, word_count=4, in_ready=0; start → full=0, next word at 0x0.
- Assert reset while out_valid=1, out_ready=0 → out_valid=0, state IDLE, out_addr=BASE_ADDR immediately; in_ready=0 until start.
